avst64_pkt_fifo: RTL

Store-and-forward packet FIFO for the 64-bit Avalon-ST bus between `pcapparser_10gbmac` (upstream source) and `pcapwriter_10gbmac` or any downstream consumer. It buffers whole frames and releases a frame downstream only once its `eop` beat has been accepted. Frames carrying a non-zero error, frames that overflow the buffer, and frames cut short by a protocol violation are discarded in full. The block absorbs downstream backpressure, so the parser never stalls mid-frame.

---
 rtl/avst64_pkt_fifo_pkg.sv | 29 ++
 rtl/avst64_pfifo_ram.sv | 22 ++
 rtl/avst64_pkt_fifo.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/avst64_pkt_fifo_pkg.sv
// Shared definitions for the 64-bit Avalon-ST store-and-forward packet FIFO:
// bus widths, the RAM word layout and the ingress FSM encoding.
package avst64_pkt_fifo_pkg;

    localparam int DATA_W  = 64;
    localparam int EMPTY_W = 3;
    localparam int ERR_W   = 6;
    localparam int WORD_W  = DATA_W + 2 + EMPTY_W;

    // Field offsets inside one RAM word; word_t below follows the same layout.
    localparam int OFS_DATA  = 0;
    localparam int OFS_SOP   = 64;
    localparam int OFS_EOP   = 65;
    localparam int OFS_EMPTY = 66;

    typedef struct packed {
        logic [EMPTY_W-1:0] empty;
        logic               eop;
        logic               sop;
        logic [DATA_W-1:0]  data;
    } word_t;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RECV    = 2'd1,
        S_DISCARD = 2'd2
    } ingress_state_t;

endpackage

// File: rtl/avst64_pfifo_ram.sv
// Simple dual-port RAM with a registered read port; the array itself is not reset.
module avst64_pfifo_ram #(
    parameter int ADDR_W = 9,
    parameter int WORD_W = 69
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/avst64_pkt_fifo.sv
// Store-and-forward packet FIFO: frames become visible downstream only after
// their eop is accepted; errored, overflowing or truncated frames are dropped.
module avst64_pkt_fifo
    import avst64_pkt_fifo_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [DATA_W-1:0]   asi_in_data,
    input  logic                asi_in_valid,
    input  logic                asi_in_sop,
    input  logic                asi_in_eop,
    input  logic [EMPTY_W-1:0]  asi_in_empty,
    input  logic [ERR_W-1:0]    asi_in_error,
    output logic                asi_in_ready,
    output logic [DATA_W-1:0]   aso_out_data,
    output logic                aso_out_valid,
    output logic                aso_out_sop,
    output logic                aso_out_eop,
    output logic [EMPTY_W-1:0]  aso_out_empty,
    output logic [ERR_W-1:0]    aso_out_error,
    input  logic                aso_out_ready,
    output logic [CNT_W-1:0]    pkt_pass_count,
    output logic [CNT_W-1:0]    pkt_drop_count
);

    ingress_state_t    state, state_n;
    logic              bad, bad_n, beat_bad, full_at_base;
    logic [ADDR_W-1:0] wr_ptr, wr_ptr_n, wr_commit, wr_commit_n, rd_ptr, base;
    logic              we, pass_inc;
    logic [1:0]        drop_inc;
    logic [CNT_W:0]    pass_sum, drop_sum;
    word_t             in_word, rd_word, skid_word, out_word;
    logic [WORD_W-1:0] ram_q;
    logic              re, rd_pend, skid_valid, out_valid, pop;
    logic [1:0]        occ;

    // Overflow is resolved by dropping, so ingress is never backpressured.
    assign asi_in_ready = reset_n;
    assign in_word = '{empty: asi_in_empty, eop: asi_in_eop, sop: asi_in_sop, data: asi_in_data};

    // A sop always restarts at the last committed point, abandoning any partial frame.
    always_comb begin
        state_n      = state;
        bad_n        = bad;
        wr_ptr_n     = wr_ptr;
        wr_commit_n  = wr_commit;
        we           = 1'b0;
        pass_inc     = 1'b0;
        drop_inc     = 2'd0;
        base         = asi_in_sop ? wr_commit : wr_ptr;
        full_at_base = (base + ADDR_W'(1)) == rd_ptr;
        beat_bad     = (asi_in_error != '0) || (bad && !asi_in_sop);
        if (asi_in_valid && (asi_in_sop || state == S_RECV)) begin
            if (asi_in_sop && state == S_RECV) drop_inc = 2'd1;
            bad_n = beat_bad;
            if (full_at_base || beat_bad) begin
                drop_inc = drop_inc + 2'd1;
                wr_ptr_n = wr_commit;
                state_n  = asi_in_eop ? S_IDLE : S_DISCARD;
            end else begin
                we       = 1'b1;
                wr_ptr_n = base + ADDR_W'(1);
                if (asi_in_eop) begin
                    wr_commit_n = base + ADDR_W'(1);
                    pass_inc    = 1'b1;
                    state_n     = S_IDLE;
                end else begin
                    state_n = S_RECV;
                end
            end
        end else if (asi_in_valid && state == S_DISCARD && asi_in_eop) begin
            state_n = S_IDLE;
        end
    end

    assign pass_sum = {1'b0, pkt_pass_count} + {{CNT_W{1'b0}}, pass_inc};
    assign drop_sum = {1'b0, pkt_drop_count} + {{(CNT_W-1){1'b0}}, drop_inc};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            bad            <= 1'b0;
            wr_ptr         <= '0;
            wr_commit      <= '0;
            pkt_pass_count <= '0;
            pkt_drop_count <= '0;
        end else begin
            state          <= state_n;
            bad            <= bad_n;
            wr_ptr         <= wr_ptr_n;
            wr_commit      <= wr_commit_n;
            pkt_pass_count <= pass_sum[CNT_W] ? '1 : pass_sum[CNT_W-1:0];
            pkt_drop_count <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
        end
    end

    avst64_pfifo_ram #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (base),
        .wdata (in_word),
        .re    (re),
        .raddr (rd_ptr),
        .rdata (ram_q)
    );
    assign rd_word = word_t'(ram_q);

    // Words in flight (output reg + skid + pending RAM read) never exceed two.
    assign pop = out_valid && aso_out_ready;
    assign occ = {1'b0, out_valid} + {1'b0, skid_valid} + {1'b0, rd_pend};
    assign re  = (rd_ptr != wr_commit) && (occ < ({1'b0, pop} + 2'd2));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr     <= '0;
            rd_pend    <= 1'b0;
            skid_valid <= 1'b0;
            skid_word  <= '0;
            out_valid  <= 1'b0;
            out_word   <= '0;
        end else begin
            rd_pend <= re;
            if (re) rd_ptr <= rd_ptr + ADDR_W'(1);
            if (!out_valid || pop) begin
                if (skid_valid) begin
                    out_word   <= skid_word;
                    out_valid  <= 1'b1;
                    skid_valid <= rd_pend;
                    if (rd_pend) skid_word <= rd_word;
                end else if (rd_pend) begin
                    out_word  <= rd_word;
                    out_valid <= 1'b1;
                end else begin
                    out_valid <= 1'b0;
                end
            end else if (rd_pend) begin
                skid_word  <= rd_word;
                skid_valid <= 1'b1;
            end
        end
    end

    assign aso_out_valid = out_valid;
    assign aso_out_data  = out_word.data;
    assign aso_out_sop   = out_word.sop;
    assign aso_out_eop   = out_word.eop;
    assign aso_out_empty = out_word.empty;
    assign aso_out_error = '0;

endmodule
